// File: rtl/pwm_pkg.sv
// Shared constants and channel-mode decode for the PWM output block.
package pwm_pkg;

  localparam int unsigned PWM_CNT_W = 8;
  localparam int unsigned NUM_CH    = 16;
  localparam logic [PWM_CNT_W-1:0] DUTY_FULL = 8'hFF;

  typedef enum logic [1:0] {CH_OFF, CH_STATIC, CH_PWM} ch_mode_e;

  function automatic ch_mode_e ch_mode(input logic en_out, input logic en_pwm);
    ch_mode_e mode;
    if (!en_out) begin
      mode = CH_OFF;
    end else if (!en_pwm) begin
      mode = CH_STATIC;
    end else begin
      mode = CH_PWM;
    end
    return mode;
  endfunction

endpackage

// File: rtl/pwm_timebase.sv
// PWM timebase: prescaler producing one tick per CLK_DIV clocks, and an 8-bit
// period counter whose 255->0 wrap marks the period boundary.
module pwm_timebase
  import pwm_pkg::*;
#(
  parameter int unsigned CLK_DIV = 3000,
  parameter int unsigned PRESC_W = 16
) (
  input  logic                 clk,
  input  logic                 rst_n,
  output logic                 tick,
  output logic [PWM_CNT_W-1:0] pwm_cnt,
  output logic                 boundary
);

  localparam logic [PRESC_W-1:0] PRESC_MAX = PRESC_W'(CLK_DIV - 1);

  logic [PRESC_W-1:0]   presc_q, presc_d;
  logic [PWM_CNT_W-1:0] cnt_q, cnt_d;

  always_comb begin
    tick     = (presc_q == PRESC_MAX);
    boundary = tick && (cnt_q == '1);
    presc_d  = tick ? '0 : presc_q + 1'b1;
    // Counter wraps naturally from 255 to 0 on the boundary tick.
    cnt_d    = tick ? cnt_q + 1'b1 : cnt_q;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      presc_q <= '0;
      cnt_q   <= '0;
    end else begin
      presc_q <= presc_d;
      cnt_q   <= cnt_d;
    end
  end

  assign pwm_cnt = cnt_q;

endmodule

// File: rtl/pwm_controller.sv
// 16-channel PWM output stage with boundary-aligned duty updates.
// Define PWM_DUTY_RAMP_EN to slew duty_active one step per period toward the target.
module pwm_controller
  import pwm_pkg::*;
#(
  parameter int unsigned CLK_DIV = 3000,
  parameter int unsigned PRESC_W = 16
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [7:0]           en_reg_out_7_0,
  input  logic [7:0]           en_reg_out_15_8,
  input  logic [7:0]           en_reg_pwm_7_0,
  input  logic [7:0]           en_reg_pwm_15_8,
  input  logic [7:0]           pwm_duty_cycle,
  output logic [NUM_CH-1:0]    out,
  output logic                 period_start,
  output logic [PWM_CNT_W-1:0] duty_active
);

  logic [NUM_CH-1:0]    en_out, en_pwm;
  logic                 tick, boundary, load_duty, pwm_hi;
  logic [PWM_CNT_W-1:0] pwm_cnt;
  logic [PWM_CNT_W-1:0] duty_q, duty_d;
  logic [NUM_CH-1:0]    out_q, out_d;
  logic                 period_start_q;

  assign en_out = {en_reg_out_15_8, en_reg_out_7_0};
  assign en_pwm = {en_reg_pwm_15_8, en_reg_pwm_7_0};

  pwm_timebase #(
    .CLK_DIV (CLK_DIV),
    .PRESC_W (PRESC_W)
  ) u_timebase (
    .clk      (clk),
    .rst_n    (rst_n),
    .tick     (tick),
    .pwm_cnt  (pwm_cnt),
    .boundary (boundary)
  );

  assign load_duty = tick && boundary;

  always_comb begin
    duty_d = duty_q;
`ifdef PWM_DUTY_RAMP_EN
    if (load_duty) begin
      if (duty_q < pwm_duty_cycle) begin
        duty_d = duty_q + 1'b1;
      end else if (duty_q > pwm_duty_cycle) begin
        duty_d = duty_q - 1'b1;
      end
    end
`else
    if (load_duty) begin
      duty_d = pwm_duty_cycle;
    end
`endif
  end

  // 0xFF is saturated high so the waveform does not drop for the cnt==255 tick.
  assign pwm_hi = (duty_q == DUTY_FULL) || (pwm_cnt < duty_q);

  always_comb begin
    out_d = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      unique case (ch_mode(en_out[i], en_pwm[i]))
        CH_OFF:    out_d[i] = 1'b0;
        CH_STATIC: out_d[i] = 1'b1;
        CH_PWM:    out_d[i] = pwm_hi;
        default:   out_d[i] = 1'b0;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      duty_q         <= '0;
      out_q          <= '0;
      period_start_q <= 1'b0;
    end else begin
      duty_q         <= duty_d;
      out_q          <= out_d;
      period_start_q <= load_duty;
    end
  end

  assign out          = out_q;
  assign period_start = period_start_q;
  assign duty_active  = duty_q;

endmodule

// File: tb/tb_pwm_controller.sv
// Directed bench for pwm_controller at CLK_DIV=4 (1024 clk per PWM period).
module tb_pwm_controller;

  localparam int unsigned CLK_DIV = 4;
  localparam int unsigned PERIOD  = 256 * CLK_DIV;

  logic        clk, rst_n;
  logic [15:0] en_out, en_pwm;
  logic [7:0]  duty;
  logic [15:0] out;
  logic        period_start;
  logic [7:0]  duty_active;

  int vecs   = 0;
  int miscmp = 0;

  pwm_controller #(
    .CLK_DIV (CLK_DIV),
    .PRESC_W (16)
  ) dut (
    .clk             (clk),
    .rst_n           (rst_n),
    .en_reg_out_7_0  (en_out[7:0]),
    .en_reg_out_15_8 (en_out[15:8]),
    .en_reg_pwm_7_0  (en_pwm[7:0]),
    .en_reg_pwm_15_8 (en_pwm[15:8]),
    .pwm_duty_cycle  (duty),
    .out             (out),
    .period_start    (period_start),
    .duty_active     (duty_active)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish, got timeout want completion");
    $fatal(1);
  end

  typedef struct {
    logic [15:0] en_out;
    logic [15:0] en_pwm;
    logic [7:0]  duty;
    bit          sync;
    int          wait_cyc;
    logic [15:0] exp_out;
    logic [7:0]  exp_duty;
  } vec_t;

  vec_t tbl[13];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    vecs++;
    if (act !== exp) begin
      miscmp++;
      $display("FAIL %s: got %h want %h", name, act, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      @(negedge clk);
    end
  endtask

  // Returns at the negedge where period_start is high; n = edges consumed.
  task automatic sync_period(output int n);
    n = 0;
    do begin
      @(posedge clk);
      @(negedge clk);
      n++;
    end while (period_start !== 1'b1 && n < 3 * PERIOD);
    if (period_start !== 1'b1) begin
      vecs++;
      miscmp++;
      $display("FAIL sync: got no period_start within %0d clk want pulse", n);
    end
  endtask

  task automatic apply(input logic [15:0] o, input logic [15:0] p, input logic [7:0] d);
    en_out = o;
    en_pwm = p;
    duty   = d;
  endtask

  int n, err, hi;
  logic [7:0] exp_ramp[4];

  initial begin
    rst_n = 1'b0;
    apply(16'h0000, 16'h0000, 8'h00);
    repeat (3) @(negedge clk);
    check("rst_out", 32'(out), 32'h0);
    check("rst_period_start", 32'(period_start), 32'h0);
    check("rst_duty_active", 32'(duty_active), 32'h0);

    rst_n = 1'b1;
    sync_period(n);
    check("first_pulse_delay", 32'(n), 32'(PERIOD));
    check("idle_out", 32'(out), 32'h0);
    step(1);
    check("pulse_width", 32'(period_start), 32'h0);
    sync_period(n);
    check("pulse_interval", 32'(n), 32'(PERIOD - 1));

`ifndef PWM_DUTY_RAMP_EN
    //         en_out     en_pwm     duty   sync  wait  exp_out    exp_duty
    tbl[0]  = '{16'hFFFF, 16'h0000, 8'h00, 1'b0, 1,    16'hFFFF, 8'h00};
    tbl[1]  = '{16'hFFFF, 16'h0000, 8'h00, 1'b1, 0,    16'hFFFF, 8'h00};
    tbl[2]  = '{16'hFFFF, 16'h0000, 8'h00, 1'b0, 700,  16'hFFFF, 8'h00};
    tbl[3]  = '{16'hFFFF, 16'h0000, 8'h00, 1'b1, 1,    16'hFFFF, 8'h00};
    tbl[4]  = '{16'h0001, 16'h0001, 8'h80, 1'b1, 1,    16'h0001, 8'h80};
    tbl[5]  = '{16'h0001, 16'h0001, 8'h80, 1'b0, 511,  16'h0001, 8'h80};
    tbl[6]  = '{16'h0001, 16'h0001, 8'h80, 1'b0, 1,    16'h0000, 8'h80};
    tbl[7]  = '{16'h0001, 16'h0001, 8'h80, 1'b0, 511,  16'h0000, 8'h80};
    tbl[8]  = '{16'h0001, 16'h0001, 8'h80, 1'b0, 1,    16'h0001, 8'h80};
    tbl[9]  = '{16'hA5C3, 16'h0FF0, 8'hFF, 1'b1, 1,    16'hA5C3, 8'hFF};
    tbl[10] = '{16'hA5C3, 16'h0FF0, 8'h00, 1'b0, 1,    16'hA5C3, 8'hFF};
    tbl[11] = '{16'hA5C3, 16'h0FF0, 8'h00, 1'b1, 1,    16'hA003, 8'h00};
    tbl[12] = '{16'h0000, 16'hFFFF, 8'hFF, 1'b0, 1,    16'h0000, 8'h00};

    for (int i = 0; i < 13; i++) begin
      apply(tbl[i].en_out, tbl[i].en_pwm, tbl[i].duty);
      if (tbl[i].sync) sync_period(n);
      step(tbl[i].wait_cyc);
      check($sformatf("vec%0d_out", i), 32'(out), 32'(tbl[i].exp_out));
      check($sformatf("vec%0d_duty", i), 32'(duty_active), 32'(tbl[i].exp_duty));
    end

    // Duty 0x00: flat low through a wrap.
    apply(16'h0001, 16'h0001, 8'h00);
    sync_period(n);
    err = 0;
    for (int i = 0; i <= 1100; i++) begin
      if (out !== 16'h0000) err++;
      step(1);
    end
    check("duty00_flat", 32'(err), 32'h0);

    // Duty 0xFF: flat high from the first cycle after the boundary, across a wrap.
    apply(16'h0001, 16'h0001, 8'hFF);
    sync_period(n);
    check("dutyff_prev_period", 32'(out), 32'h0);
    err = 0;
    for (int i = 1; i <= 1100; i++) begin
      step(1);
      if (out !== 16'h0001) err++;
    end
    check("dutyff_flat", 32'(err), 32'h0);

    // Mid-period duty change 0x40 -> 0xC0 waits for the boundary.
    apply(16'h0001, 16'h0001, 8'h40);
    sync_period(n);
    check("d40_active", 32'(duty_active), 32'h40);
    hi = 0;
    for (int i = 1; i <= PERIOD; i++) begin
      step(1);
      if (out[0] === 1'b1) hi++;
      if (i == 300) duty = 8'hC0;
      if (i == 301) check("d40_held_midperiod", 32'(duty_active), 32'h40);
    end
    check("d40_high_clks", 32'(hi), 32'(64 * CLK_DIV));
    check("dC0_pulse", 32'(period_start), 32'h1);
    check("dC0_active", 32'(duty_active), 32'hC0);
    hi = 0;
    for (int i = 1; i <= PERIOD; i++) begin
      step(1);
      if (out[0] === 1'b1) hi++;
    end
    check("dC0_high_clks", 32'(hi), 32'(192 * CLK_DIV));
`endif

    // Asynchronous reset mid-period.
    apply(16'h0001, 16'h0001, 8'h80);
    sync_period(n);
    step(10);
`ifndef PWM_DUTY_RAMP_EN
    check("pre_reset_out", 32'(out), 32'h0001);
`endif
    #2 rst_n = 1'b0;
    #1;
    check("midrst_out", 32'(out), 32'h0);
    check("midrst_duty", 32'(duty_active), 32'h0);
    check("midrst_period_start", 32'(period_start), 32'h0);
    check("midrst_pwm_cnt", 32'(dut.pwm_cnt), 32'h0);

`ifdef PWM_DUTY_RAMP_EN
    exp_ramp = '{8'h01, 8'h02, 8'h03, 8'h03};
`else
    exp_ramp = '{8'h03, 8'h03, 8'h03, 8'h03};
`endif
    duty = 8'h03;
    @(negedge clk);
    rst_n = 1'b1;
    for (int k = 0; k < 4; k++) begin
      sync_period(n);
      if (k == 0) check("post_rst_first_pulse", 32'(n), 32'(PERIOD));
      check($sformatf("post_rst_duty%0d", k), 32'(duty_active), 32'(exp_ramp[k]));
    end

    $display("== %0d vectors applied, %0d miscompares ==", vecs, miscmp);
    $finish;
  end

endmodule
